multi_rate_tick_gen: RTL

//  Parametrised, runtime-programmable multi-channel clock divider. Generates NUM_CH

---
 rtl/multi_rate_tick_gen.sv | 91 +++++++++
 1 files changed

// File: rtl/multi_rate_tick_gen.sv
// Multi-channel runtime-programmable tick/square divider.
// Each channel emits a 1-cycle tick every De enabled cycles (De = max(D,1))
// and a square wave that toggles on every tick. Shared sync realigns all
// channels; cfg port rewrites one channel's divide value.
module multi_rate_tick_gen #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 26,
  parameter int DEFAULT_DIV = 2500000,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clkIn,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    sync,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [CNT_W-1:0]        cfg_div,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       sq,
  output logic [NUM_CH*CNT_W-1:0] div_rd
);

  logic [CNT_W-1:0]  div_q [NUM_CH];
  logic [CNT_W-1:0]  div_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] sq_q, sq_d;
  logic [NUM_CH-1:0] cfg_hit;

  // Next-state per channel: sync beats cfg write beats counting.
  always_comb begin
    div_d   = div_q;
    cnt_d   = cnt_q;
    tick_d  = '0;
    sq_d    = sq_q;
    cfg_hit = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cfg_hit[i] = cfg_we && (cfg_ch == CH_W'(i));
      if (cfg_hit[i]) begin
        div_d[i] = cfg_div;
      end
      if (sync) begin
        cnt_d[i] = '0;
        sq_d[i]  = 1'b0;
      end else if (cfg_hit[i]) begin
        cnt_d[i] = '0;
      end else if (ch_en[i]) begin
        // D of 0 or 1 behaves as divide-by-1: wrap on every enabled cycle.
        if ((div_q[i] < CNT_W'(2)) || (cnt_q[i] == div_q[i] - CNT_W'(1))) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          sq_d[i]   = ~sq_q[i];
        end else begin
          cnt_d[i]  = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // State registers with synchronous reset to the default divide value.
  always_ff @(posedge clkIn) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        div_q[i] <= CNT_W'(DEFAULT_DIV);
        cnt_q[i] <= '0;
      end
      tick_q <= '0;
      sq_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end

  // Flatten divide values for readback, channel 0 in the LSBs.
  always_comb begin
    div_rd = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      div_rd[i*CNT_W +: CNT_W] = div_q[i];
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;

endmodule
